// File: rtl/breakout_game_sequencer_pkg.sv
// breakout_game_sequencer_pkg: state codes and game constants shared with the ball/brick datapath
package breakout_game_sequencer_pkg;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SERVE = 3'd2,
        ST_PLAY  = 3'd3,
        ST_PAUSE = 3'd4,
        ST_MISS  = 3'd5,
        ST_WIN   = 3'd6,
        ST_OVER  = 3'd7
    } state_t;
    localparam int TICK_DIV_DEF = 4194304;
    localparam int MISS_Y_DEF = 470;
    localparam logic [9:0] SERVE_X = 10'd320;
    localparam logic [9:0] SERVE_Y = 10'd240;
    localparam logic signed [3:0] SERVE_VX = 4'sd1;
    localparam logic signed [3:0] SERVE_VY = -4'sd1;
endpackage

// File: rtl/breakout_game_sequencer_tick_prescaler.sv
// breakout_game_sequencer_tick_prescaler: divides clk into a tick every TICK_DIV cycles, with hold and clear
module breakout_game_sequencer_tick_prescaler
    import breakout_game_sequencer_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    assign tick = cnt_q == W'(TICK_DIV - 1);
    always_comb cnt_d = clr ? '0 : en ? (tick ? '0 : cnt_q + 1'b1) : cnt_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/breakout_game_sequencer.sv
// breakout_game_sequencer: game flow FSM producing the game tick enable, level/serve pulses, lives, score and bricks
module breakout_game_sequencer
    import breakout_game_sequencer_pkg::*;
#(
    parameter int TICK_DIV    = TICK_DIV_DEF,
    parameter int SERVE_TICKS = 32,
    parameter int LIVES       = 3,
    parameter int MISS_Y      = MISS_Y_DEF,
    parameter int POINTS      = 10,
    parameter int SCORE_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_pulse,
    input  logic               pause_pulse,
    input  logic               brick_hit,
    input  logic [8:0]         init_bricks,
    input  logic [9:0]         ball_y,
    output logic               game_tick,
    output logic               load_level,
    output logic               serve,
    output logic [2:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic [8:0]         bricks_left,
    output logic [2:0]         state
);
    localparam int SW = $clog2(SERVE_TICKS + 1);
    state_t state_q, state_d;
    logic [2:0] lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [8:0] bricks_q, bricks_d;
    logic [SW-1:0] svc_q, svc_d;
    logic game_tick_q, game_tick_d, load_level_q, load_level_d, serve_q, serve_d;
    logic tick, run, hit, missed;
    logic [SCORE_W:0] sum;
    assign run = state_q == ST_SERVE || state_q == ST_PLAY;
    breakout_game_sequencer_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .clr  (!run && state_q != ST_PAUSE),
        .tick (tick)
    );
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        score_d = score_q;
        bricks_d = bricks_q;
        svc_d = '0;
        sum = {1'b0, score_q} + (SCORE_W + 1)'(POINTS);
        hit = brick_hit && bricks_q != 9'd0;
        missed = game_tick_q && ball_y >= 10'(MISS_Y);
        case (state_q)
            ST_IDLE: state_d = start_pulse ? ST_LOAD : ST_IDLE;
            ST_LOAD: begin
                score_d = '0;
                lives_d = 3'(LIVES);
                bricks_d = init_bricks;
                state_d = ST_SERVE;
            end
            ST_SERVE: begin
                svc_d = svc_q + SW'(tick);
                state_d = bricks_q == 9'd0 ? ST_WIN :
                          (tick && svc_q == SW'(SERVE_TICKS - 1)) ? ST_PLAY : ST_SERVE;
            end
            ST_PLAY: begin
                if (hit) begin
                    bricks_d = bricks_q - 1'b1;
                    score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
                end
                // clearing the last brick wins even if the ball is lost on the same tick
                state_d = (hit && bricks_q == 9'd1) ? ST_WIN : missed ? ST_MISS :
                          pause_pulse ? ST_PAUSE : ST_PLAY;
            end
            ST_PAUSE: state_d = pause_pulse ? ST_PLAY : start_pulse ? ST_LOAD : ST_PAUSE;
            ST_MISS: begin
                lives_d = lives_q - 1'b1;
                state_d = lives_q == 3'd1 ? ST_OVER : ST_SERVE;
            end
            ST_WIN, ST_OVER: state_d = start_pulse ? ST_LOAD : state_q;
        endcase
        game_tick_d = tick && state_q == ST_PLAY && state_d == ST_PLAY;
        load_level_d = state_d == ST_LOAD;
        serve_d = state_d == ST_SERVE && state_q != ST_SERVE;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= ST_IDLE;
            lives_q <= 3'(LIVES);
            score_q <= '0;
            bricks_q <= '0;
            svc_q <= '0;
            game_tick_q <= 1'b0;
            load_level_q <= 1'b0;
            serve_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            score_q <= score_d;
            bricks_q <= bricks_d;
            svc_q <= svc_d;
            game_tick_q <= game_tick_d;
            load_level_q <= load_level_d;
            serve_q <= serve_d;
        end
    assign game_tick = game_tick_q;
    assign load_level = load_level_q;
    assign serve = serve_q;
    assign lives = lives_q;
    assign score = score_q;
    assign bricks_left = bricks_q;
    assign state = state_q;
endmodule

// File: tb/tb_breakout_game_sequencer.sv
// tb_breakout_game_sequencer: directed game scenarios plus random play checked against a rule-level model
module tb_breakout_game_sequencer;
    localparam int TDIV = 4, STK = 2, NLV = 2, PTS = 10, MY = 470, SMAX = 65535;
    logic clk, rst, start_pulse, pause_pulse, brick_hit;
    logic [8:0] init_bricks;
    logic [9:0] ball_y;
    logic game_tick, load_level, serve;
    logic [2:0] lives, state;
    logic [15:0] score;
    logic [8:0] bricks_left;
    int n_cmp = 0, n_err = 0;
    int m_st, m_pre, m_svc, m_lives, m_score, m_bricks;
    bit m_gt, m_ld, m_sv;

    breakout_game_sequencer #(
        .TICK_DIV(TDIV), .SERVE_TICKS(STK), .LIVES(NLV), .MISS_Y(MY), .POINTS(PTS), .SCORE_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start_pulse(start_pulse), .pause_pulse(pause_pulse),
        .brick_hit(brick_hit), .init_bricks(init_bricks), .ball_y(ball_y),
        .game_tick(game_tick), .load_level(load_level), .serve(serve), .lives(lives),
        .score(score), .bricks_left(bricks_left), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_pre = 0; m_svc = 0; m_lives = NLV; m_score = 0; m_bricks = 0;
        m_gt = 0; m_ld = 0; m_sv = 0;
    endtask

    // one clock of the game rules; states use the published numeric codes
    task automatic model_step();
        int ns;
        bit tk;
        if (!rst) begin
            model_reset();
            return;
        end
        tk = (m_pre == TDIV - 1);
        ns = m_st;
        case (m_st)
            0: if (start_pulse) ns = 1;
            1: begin m_score = 0; m_lives = NLV; m_bricks = int'(init_bricks); ns = 2; end
            2: if (m_bricks == 0) ns = 6; else if (tk && m_svc + 1 == STK) ns = 3;
            3: begin
                if (brick_hit && m_bricks > 0) begin
                    m_bricks--;
                    m_score = (m_score + PTS > SMAX) ? SMAX : m_score + PTS;
                    if (m_bricks == 0) ns = 6;
                end
                if (ns == 3) ns = (m_gt && int'(ball_y) >= MY) ? 5 : pause_pulse ? 4 : 3;
            end
            4: ns = pause_pulse ? 3 : start_pulse ? 1 : 4;
            5: begin m_lives--; ns = (m_lives == 0) ? 7 : 2; end
            default: if (start_pulse) ns = 1;
        endcase
        m_svc = (m_st == 2) ? m_svc + int'(tk) : 0;
        m_gt = tk && m_st == 3 && ns == 3;
        m_ld = (ns == 1);
        m_sv = (ns == 2 && m_st != 2);
        m_pre = (m_st == 2 || m_st == 3) ? (tk ? 0 : m_pre + 1) : (m_st == 4 ? m_pre : 0);
        m_st = ns;
    endtask

    task automatic cmp_all();
        check("state", 32'(state), m_st);
        check("lives", 32'(lives), m_lives);
        check("score", 32'(score), m_score);
        check("bricks_left", 32'(bricks_left), m_bricks);
        check("game_tick", 32'(game_tick), 32'(m_gt));
        check("load_level", 32'(load_level), 32'(m_ld));
        check("serve", 32'(serve), 32'(m_sv));
    endtask

    task automatic cyc(input bit s, input bit p, input bit h);
        start_pulse = s; pause_pulse = p; brick_hit = h;
        @(posedge clk);
        model_step();
        #1 cmp_all();
        @(negedge clk);
    endtask

    task automatic run_to(input int target, input int bound, output int n);
        n = 0;
        while (int'(state) != target && n < bound) begin
            cyc(0, 0, 0);
            n++;
        end
        check("reach_state", 32'(state), target);
    endtask

    task automatic async_reset();
        rst = 1'b0;
        #1 model_reset();
        cmp_all();
        cyc(0, 0, 0);
        rst = 1'b1;
    endtask

    initial begin
        int n, k, gts;
        rst = 1'b0; start_pulse = 0; pause_pulse = 0; brick_hit = 0;
        init_bricks = 9'd3; ball_y = 10'd100;
        model_reset();
        @(negedge clk);
        cmp_all();
        rst = 1'b1;
        cyc(0, 0, 0);
        // level start: load, serve, play latency, tick period
        cyc(1, 0, 0);
        check("load_pulse", 32'(load_level), 1);
        cyc(0, 0, 0);
        check("serve_pulse", 32'(serve), 1);
        n = 2;
        while (int'(state) != 3 && n < 30) begin cyc(0, 0, 0); n++; end
        check("play_latency", n, 10);
        check("lives_start", 32'(lives), NLV);
        check("bricks_start", 32'(bricks_left), 3);
        k = 0;
        while (!game_tick && k < 20) begin cyc(0, 0, 0); k++; end
        k = 0;
        do begin cyc(0, 0, 0); k++; end while (!game_tick && k < 20);
        check("tick_period", k, TDIV);
        // clear the level with three hits
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 1);
            check("hit_score", 32'(score), i * PTS);
        end
        check("win_state", 32'(state), 6);
        gts = 0;
        for (int i = 0; i < 8; i++) begin cyc(0, 0, 0); gts += int'(game_tick); end
        check("win_no_tick", gts, 0);
        check("win_score_hold", 32'(score), 30);
        // lose both lives
        cyc(1, 0, 0);
        run_to(3, 20, n);
        ball_y = 10'd470;
        run_to(5, 12, n);
        ball_y = 10'd100;
        cyc(0, 0, 0);
        check("miss_lives", 32'(lives), 1);
        check("miss_serve", 32'(serve), 1);
        run_to(3, 20, n);
        ball_y = 10'd470;
        run_to(5, 12, n);
        ball_y = 10'd100;
        cyc(0, 0, 0);
        check("over_state", 32'(state), 7);
        check("over_lives", 32'(lives), 0);
        cyc(1, 0, 0);
        check("restart_load", 32'(state), 1);
        cyc(0, 0, 0);
        check("restart_lives", 32'(lives), NLV);
        check("restart_score", 32'(score), 0);
        // last brick and miss on the same tick
        run_to(3, 20, n);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        k = 0;
        while (!game_tick && k < 10) begin cyc(0, 0, 0); k++; end
        ball_y = 10'd475;
        cyc(0, 0, 1);
        ball_y = 10'd100;
        check("hit_beats_miss", 32'(state), 6);
        check("hit_beats_miss_lives", 32'(lives), NLV);
        // pause at prescaler count 2 and resume
        cyc(1, 0, 0);
        run_to(3, 20, n);
        k = 0;
        while (m_pre != 2 && k < 10) begin cyc(0, 0, 0); k++; end
        cyc(0, 1, 0);
        check("pause_state", 32'(state), 4);
        gts = 0;
        for (int i = 0; i < 20; i++) begin cyc(0, 0, 0); gts += int'(game_tick); end
        check("pause_no_tick", gts, 0);
        cyc(0, 1, 0);
        k = 1;
        while (!game_tick && k < 10) begin cyc(0, 0, 0); k++; end
        check("resume_tick", k, 2);
        // reset mid-play, then an empty level
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
        rst = 1'b0;
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_score", 32'(score), 0);
        check("rst_lives", 32'(lives), NLV);
        check("rst_tick", 32'(game_tick), 0);
        model_reset();
        cyc(0, 0, 0);
        rst = 1'b1;
        init_bricks = 9'd0;
        cyc(1, 0, 0);
        check("empty_load", 32'(state), 1);
        cyc(0, 0, 0);
        check("empty_serve", 32'(state), 2);
        cyc(0, 0, 0);
        check("empty_win", 32'(state), 6);
        // random play
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) async_reset();
            init_bricks = 9'($urandom_range(0, 6));
            ball_y = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(470, 1023)) : 10'($urandom_range(0, 469));
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
